// File: rtl/fp_to_fixed_serial.sv
// Block-floating (Q1.15 mantissa, signed 8-bit exponent) to two's-complement fixed point.
// Uses a one-bit-per-cycle serial shifter with saturation on left shifts and round-half-up on right shifts.
module fp_to_fixed_serial #(
  parameter int OUT_W = 24,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      ma,
  input  logic [7:0]       ea,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] fx,
  output logic             sat,
  output logic             uflow
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             sat_q, sat_d;
  logic             nz_q, nz_d;

  logic [9:0]       s;
  logic [9:0]       s_mag;
  logic [OUT_W-1:0] shr;

  // Shift amount as a 10-bit two's-complement value; the exponent range plus FRAC cannot overflow it.
  assign s     = {{2{ea[7]}}, ea} + 10'(FRAC) - 10'd15;
  assign s_mag = 10'd0 - s;
  assign shr   = {acc_q[OUT_W-1], acc_q[OUT_W-1:1]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    sat_d   = sat_q;
    nz_d    = nz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d  = {{(OUT_W-16){ma[15]}}, ma};
          left_d = !s[9];
          nz_d   = (ma != 16'd0);
          sat_d  = 1'b0;
          if (ma == 16'd0) begin
            cnt_d = '0;
          end else if (s[9]) begin
            // Beyond 17 right shifts every mantissa rounds to zero, so longer shifts are clamped.
            cnt_d = (s_mag > 10'd17) ? CNT_W'(17) : s_mag[CNT_W-1:0];
          end else begin
            cnt_d = (s > 10'(OUT_W)) ? CNT_W'(OUT_W) : s[CNT_W-1:0];
          end
          state_d = (cnt_d == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (left_q) begin
          if (acc_q[OUT_W-1] != acc_q[OUT_W-2]) begin
            acc_d   = acc_q[OUT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            sat_d   = 1'b1;
            state_d = DONE;
          end else begin
            acc_d = {acc_q[OUT_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            acc_d   = shr + {{(OUT_W-1){1'b0}}, acc_q[0]};
            state_d = DONE;
          end else begin
            acc_d = shr;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      sat_q   <= 1'b0;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      sat_q   <= sat_d;
      nz_q    <= nz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign fx        = out_valid ? acc_q : '0;
  assign sat       = out_valid & sat_q;
  assign uflow     = out_valid & nz_q & (acc_q == '0);

endmodule
